// File: rtl/posit_acc_seq.sv
// posit_acc_seq: sequential front-end that sums a stream of posit terms through an
// external single-cycle combinational posit adder, with a sticky NaR flag and an
// adder-timeout error.
module posit_acc_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned TMO   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic [N-1:0]     add_in1,
    output logic [N-1:0]     add_in2,
    output logic             add_start,
    input  logic [N-1:0]     add_out,
    input  logic             add_inf,
    input  logic             add_zero,
    input  logic             add_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_inf,
    output logic             res_err,
    output logic [LEN_W-1:0] res_count
);

    localparam int unsigned TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TmrLast = TW'(TMO - 1);
    localparam logic [N-1:0] NaR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StLoad, StFeed, StAdd, StOut} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     opb_q, opb_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             inf_s_q, inf_s_d;
    logic             err_s_q, err_s_d;
    // Result copies: acc/cnt are reused by the next job before its OUT, so the
    // presented result is latched separately and held until the next OUT.
    logic [N-1:0]     rdata_q, rdata_d;
    logic             rinf_q, rinf_d;
    logic             rerr_q, rerr_d;
    logic [LEN_W-1:0] rcnt_q, rcnt_d;

    logic [LEN_W-1:0] cnt_inc;
    logic             unused_zero;

    assign cnt_inc     = cnt_q + LEN_W'(1);
    assign unused_zero = add_zero;

    // Moore outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        in_ready  = (state_q == StLoad) || (state_q == StFeed);
        add_start = (state_q == StAdd);
        res_valid = (state_q == StOut);
        add_in1   = acc_q;
        add_in2   = opb_q;
        res_data  = rdata_q;
        res_inf   = rinf_q;
        res_err   = rerr_q;
        res_count = rcnt_q;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        inf_s_d = inf_s_q;
        err_s_d = err_s_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    inf_s_d = 1'b0;
                    err_s_d = 1'b0;
                    if (cmd_len == '0) begin
                        acc_d   = '0;
                        state_d = StOut;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = LEN_W'(1);
                    inf_s_d = (in_data == NaR);
                    state_d = (len_q == LEN_W'(1)) ? StOut : StFeed;
                end
            end
            StFeed: begin
                if (in_valid) begin
                    opb_d   = in_data;
                    inf_s_d = inf_s_q | (in_data == NaR);
                    tmr_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                if (add_done) begin
                    acc_d   = (add_inf | inf_s_q) ? NaR : add_out;
                    inf_s_d = inf_s_q | add_inf;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? StOut : StFeed;
                end else if (tmr_q == TmrLast) begin
                    err_s_d = 1'b1;
                    acc_d   = NaR;
                    state_d = StOut;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StOut: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Latch the result with the values that take effect as OUT is (re)entered.
    always_comb begin
        rdata_d = rdata_q;
        rinf_d  = rinf_q;
        rerr_d  = rerr_q;
        rcnt_d  = rcnt_q;
        if (state_d == StOut) begin
            rdata_d = acc_d;
            rinf_d  = inf_s_d;
            rerr_d  = err_s_d;
            rcnt_d  = cnt_d;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            opb_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            inf_s_q <= 1'b0;
            err_s_q <= 1'b0;
            rdata_q <= '0;
            rinf_q  <= 1'b0;
            rerr_q  <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            inf_s_q <= inf_s_d;
            err_s_q <= err_s_d;
            rdata_q <= rdata_d;
            rinf_q  <= rinf_d;
            rerr_q  <= rerr_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_posit_acc_seq.sv
// Directed bench for posit_acc_seq with a small lookup-table stand-in for the adder.
module tb_posit_acc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic        add_start;
    logic [31:0] add_out;
    logic        add_inf;
    logic        add_zero;
    logic        add_done;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_inf;
    logic        res_err;
    logic [7:0]  res_count;

    logic        done_en;
    logic [31:0] terms [0:7];
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] NAR = 32'h8000_0000;

    always #5 clk = ~clk;

    posit_acc_seq #(.N(32), .LEN_W(8), .TMO(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_start (add_start),
        .add_out   (add_out),
        .add_inf   (add_inf),
        .add_zero  (add_zero),
        .add_done  (add_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_inf   (res_inf),
        .res_err   (res_err),
        .res_count (res_count)
    );

    // Posit32 (es=2) sums for the values this bench uses: 1.0, -1.0, 2.0, 3.0, 4.0.
    function automatic logic [32:0] add_model(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR || b == NAR) return {1'b1, NAR};
        case ({a, b})
            {32'h4000_0000, 32'h4000_0000}: return {1'b0, 32'h4800_0000};
            {32'h4800_0000, 32'h4000_0000}: return {1'b0, 32'h4C00_0000};
            {32'h4C00_0000, 32'h4000_0000}: return {1'b0, 32'h5000_0000};
            {32'h4000_0000, 32'hC000_0000}: return {1'b0, 32'h0000_0000};
            default:                        return {1'b0, 32'hDEAD_BEEF};
        endcase
    endfunction

    assign {add_inf, add_out} = add_model(add_in1, add_in2);
    assign add_zero = (add_out == 32'h0);
    assign add_done = add_start & done_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one job, stream terms[], check the result and its hold behaviour.
    task automatic run_job(input int len, input bit rand_v, input int hold, input int exp_lat,
                           input logic [31:0] exp_data, input logic exp_inf,
                           input logic exp_err, input int exp_cnt, input int exp_starts);
        int idx;
        int cyc;
        int starts;
        bit hs;
        logic [31:0] d0;
        logic [7:0]  c0;
        logic        i0;
        logic        e0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = len[7:0];
        @(negedge clk);
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1; idx = 0; starts = 0;
        in_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = terms[0];
        while (cyc < 300) begin
            @(negedge clk);
            if (res_valid) break;
            if (add_start) starts++;
            if (in_ready) check("in_ready_state", {29'b0, add_start, res_valid, cmd_ready}, 32'd0);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
            in_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = terms[idx & 7];
        end
        in_valid = 1'b0;
        check("res_valid_seen", {31'b0, res_valid}, 32'd1);
        if (exp_lat >= 0) check("latency", cyc, exp_lat);
        check("res_data", res_data, exp_data);
        check("res_inf", {31'b0, res_inf}, {31'b0, exp_inf});
        check("res_err", {31'b0, res_err}, {31'b0, exp_err});
        check("res_count", {24'b0, res_count}, exp_cnt);
        check("add_starts", starts, exp_starts);
        d0 = res_data; c0 = res_count; i0 = res_inf; e0 = res_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", {31'b0, res_valid}, 32'd1);
            check("hold_stable", {res_data[31:10] ^ d0[31:10], res_data[9:0] ^ d0[9:0]}
                  | {22'b0, res_count ^ c0, res_inf ^ i0, res_err ^ e0}, 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_drop", {31'b0, res_valid}, 32'd0);
        check("res_data_kept", res_data, exp_data);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'd0; in_valid = 1'b0; in_data = 32'h0;
        res_ready = 1'b0; done_en = 1'b1;
        for (int i = 0; i < 8; i++) terms[i] = 32'h4000_0000;
        #12;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_add", {add_in1 | add_in2} | {31'b0, add_start}, 32'd0);
        check("rst_res", res_data | {23'b0, res_count, res_valid} | {30'b0, res_inf, res_err},
              32'd0);
        #1 rst = 1'b0;

        // 1+1+1+1 = 4.0
        run_job(4, 1'b0, 0, 8, 32'h5000_0000, 1'b0, 1'b0, 4, 3);
        // 1 + (-1) = 0
        terms[1] = 32'hC000_0000;
        run_job(2, 1'b0, 0, 4, 32'h0000_0000, 1'b0, 1'b0, 2, 1);
        // single term passes straight through, no adder use
        terms[0] = 32'h4800_0000;
        run_job(1, 1'b0, 0, 2, 32'h4800_0000, 1'b0, 1'b0, 1, 0);
        // NaR in the middle poisons the sum
        terms[0] = 32'h4000_0000; terms[1] = NAR; terms[2] = 32'h4000_0000;
        run_job(3, 1'b0, 0, 6, NAR, 1'b1, 1'b0, 3, 2);
        // empty job
        run_job(0, 1'b0, 0, 1, 32'h0, 1'b0, 1'b0, 0, 0);
        // adder never completes: timeout after 15 ADD cycles
        terms[1] = 32'h4000_0000;
        done_en = 1'b0;
        run_job(2, 1'b0, 0, 18, NAR, 1'b0, 1'b1, 1, 15);
        done_en = 1'b1;
        // random in_valid gaps, result held for 10 cycles
        run_job(4, 1'b1, 10, -1, 32'h5000_0000, 1'b0, 1'b0, 4, 3);

        // asynchronous reset while in ADD
        done_en = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_len = 8'd2; in_valid = 1'b1; in_data = 32'h4000_0000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (add_start) break;
        end
        check("reached_add", {31'b0, add_start}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("arst_add_start", {31'b0, add_start}, 32'd0);
        check("arst_add_in", add_in1 | add_in2, 32'd0);
        check("arst_res", res_data | {23'b0, res_count, res_valid}, 32'd0);
        #1 rst = 1'b0;
        in_valid = 1'b0; done_en = 1'b1;
        run_job(2, 1'b0, 0, 4, 32'h4800_0000, 1'b0, 1'b0, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
